// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the EX-stage branch resolution unit.
package branch_resolve_unit_pkg;

    // Resolution FSM: IDLE resolves, FLUSH is the single-cycle flush slot.
    typedef enum logic [0:0] {
        BruIdle  = 1'b0,
        BruFlush = 1'b1
    } bru_state_e;

    // Sequential next-PC increment for a not-taken branch.
    localparam int unsigned PcIncr = 4;

    // One-hot conditional branch kind.
    typedef struct packed {
        logic beq;
        logic bne;
        logic blt;
        logic bge;
        logic bltu;
        logic bgeu;
    } br_kind_t;

endpackage

// File: rtl/branch_resolve_unit_comparator.sv
// Branch comparator: combinational (kind, rs1, rs2) -> taken.
module branch_resolve_unit_comparator
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  br_kind_t        kind_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    // Evaluate all three relations and select by the one-hot kind.
    always_comb begin
        eq      = (rs1_i == rs2_i);
        lt_s    = ($signed(rs1_i) < $signed(rs2_i));
        lt_u    = (rs1_i < rs2_i);
        taken_o = (kind_i.beq  &  eq)   |
                  (kind_i.bne  & ~eq)   |
                  (kind_i.blt  &  lt_s) |
                  (kind_i.bge  & ~lt_s) |
                  (kind_i.bltu &  lt_u) |
                  (kind_i.bgeu & ~lt_u);
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution and flush controller.
// Optional perf counters are built only when BRU_PERF_CNT_EN is defined; otherwise the
// counter ports are tied to zero.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PERF_CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pl_stall_i,
    input  logic                  pl_stall_inner_i,
    input  logic                  b_type_i,
    input  logic                  beq_i,
    input  logic                  bne_i,
    input  logic                  blt_i,
    input  logic                  bge_i,
    input  logic                  bltu_i,
    input  logic                  bgeu_i,
    input  logic                  jalr_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [XLEN-1:0]       imme_i,
    input  logic [XLEN-1:0]       rs1_data_i,
    input  logic [XLEN-1:0]       rs2_data_i,
    input  logic                  prediction_ex_i,
    input  logic [XLEN-1:0]       jalr_pc_predicted_ex_i,
    output logic                  corrected_result_o,
    output logic                  pl_flush_o,
    output logic [XLEN-1:0]       redirect_pc_o,
    output logic                  b_type_branch_failed_o,
    output logic                  beq_branch_failed_o,
    output logic                  bne_branch_failed_o,
    output logic                  blt_branch_failed_o,
    output logic                  bge_branch_failed_o,
    output logic                  bltu_branch_failed_o,
    output logic                  bgeu_branch_failed_o,
    output logic [XLEN-1:0]       pc_branch_filled_o,
    output logic                  b_type_result_branch_failed_o,
    output logic [PERF_CNT_W-1:0] mispredict_cnt_o,
    output logic [PERF_CNT_W-1:0] resolved_cnt_o
);

    bru_state_e      state_q;
    br_kind_t        kind;
    br_kind_t        kind_failed_q;
    logic            taken;
    logic            resolve_en;
    logic            b_mispredict;
    logic            j_mispredict;
    logic            mispredict;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] redirect_d;
    logic [XLEN-1:0] redirect_q;
    logic [XLEN-1:0] pc_failed_q;
    logic            flush_q;
    logic            b_failed_q;
    logic            result_failed_q;

    assign kind = '{beq: beq_i, bne: bne_i, blt: blt_i, bge: bge_i, bltu: bltu_i, bgeu: bgeu_i};

    branch_resolve_unit_comparator #(
        .XLEN (XLEN)
    ) u_cmp (
        .kind_i  (kind),
        .rs1_i   (rs1_data_i),
        .rs2_i   (rs2_data_i),
        .taken_o (taken)
    );

    // Mispredict detection and redirect target; EX input is wrong-path while flushing.
    always_comb begin
        corrected_result_o = b_type_i & taken & (state_q == BruIdle);
        resolve_en   = (b_type_i | jalr_i) & ~pl_stall_i & ~pl_stall_inner_i
                       & (state_q == BruIdle);
        jalr_target  = (rs1_data_i + imme_i) & ~XLEN'(1);
        b_mispredict = resolve_en & b_type_i & (corrected_result_o != prediction_ex_i);
        j_mispredict = resolve_en & jalr_i & ~b_type_i & (jalr_target != jalr_pc_predicted_ex_i);
        mispredict   = b_mispredict | j_mispredict;
        if (b_type_i) begin
            redirect_d = corrected_result_o ? (pc_i + imme_i) : (pc_i + XLEN'(PcIncr));
        end else begin
            redirect_d = jalr_target;
        end
    end

    // Resolution FSM with registered flush and rollback bundle (zero outside FLUSH).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= BruIdle;
            flush_q         <= 1'b0;
            redirect_q      <= '0;
            b_failed_q      <= 1'b0;
            kind_failed_q   <= '0;
            pc_failed_q     <= '0;
            result_failed_q <= 1'b0;
        end else begin
            unique case (state_q)
                BruIdle: begin
                    if (mispredict) begin
                        state_q         <= BruFlush;
                        flush_q         <= 1'b1;
                        redirect_q      <= redirect_d;
                        b_failed_q      <= b_mispredict;
                        kind_failed_q   <= b_mispredict ? kind : '0;
                        pc_failed_q     <= pc_i;
                        result_failed_q <= prediction_ex_i;
                    end else begin
                        flush_q         <= 1'b0;
                        redirect_q      <= '0;
                        b_failed_q      <= 1'b0;
                        kind_failed_q   <= '0;
                        pc_failed_q     <= '0;
                        result_failed_q <= 1'b0;
                    end
                end
                BruFlush: begin
                    state_q         <= BruIdle;
                    flush_q         <= 1'b0;
                    redirect_q      <= '0;
                    b_failed_q      <= 1'b0;
                    kind_failed_q   <= '0;
                    pc_failed_q     <= '0;
                    result_failed_q <= 1'b0;
                end
                default: state_q <= BruIdle;
            endcase
        end
    end

    assign pl_flush_o                    = flush_q;
    assign redirect_pc_o                 = redirect_q;
    assign b_type_branch_failed_o        = b_failed_q;
    assign beq_branch_failed_o           = kind_failed_q.beq;
    assign bne_branch_failed_o           = kind_failed_q.bne;
    assign blt_branch_failed_o           = kind_failed_q.blt;
    assign bge_branch_failed_o           = kind_failed_q.bge;
    assign bltu_branch_failed_o          = kind_failed_q.bltu;
    assign bgeu_branch_failed_o          = kind_failed_q.bgeu;
    assign pc_branch_filled_o            = pc_failed_q;
    assign b_type_result_branch_failed_o = result_failed_q;

`ifdef BRU_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] resolved_q;
    logic [PERF_CNT_W-1:0] mispred_q;

    // Saturating perf counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resolved_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (resolve_en && (resolved_q != '1)) resolved_q <= resolved_q + 1'b1;
            if (mispredict && (mispred_q != '1))  mispred_q  <= mispred_q + 1'b1;
        end
    end

    assign resolved_cnt_o   = resolved_q;
    assign mispredict_cnt_o = mispred_q;
`else
    assign resolved_cnt_o   = '0;
    assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit.
module tb_branch_resolve_unit;

    localparam int unsigned PCW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            pl_stall, pl_stall_inner, b_type, jalr, prediction_ex;
    logic            beq, bne, blt, bge, bltu, bgeu;
    logic [31:0]     pc, imme, rs1_data, rs2_data, jalr_pc_predicted_ex;
    logic            corrected_result, pl_flush;
    logic [31:0]     redirect_pc, pc_branch_filled;
    logic            b_type_branch_failed, b_type_result_branch_failed;
    logic            beq_f, bne_f, blt_f, bge_f, bltu_f, bgeu_f;
    logic [PCW-1:0]  mispredict_cnt, resolved_cnt;

    int n_vec = 0;
    int n_err = 0;

    branch_resolve_unit #(
        .XLEN       (32),
        .PERF_CNT_W (PCW)
    ) dut (
        .clk_i                         (clk),
        .rst_i                         (rst),
        .pl_stall_i                    (pl_stall),
        .pl_stall_inner_i              (pl_stall_inner),
        .b_type_i                      (b_type),
        .beq_i                         (beq),
        .bne_i                         (bne),
        .blt_i                         (blt),
        .bge_i                         (bge),
        .bltu_i                        (bltu),
        .bgeu_i                        (bgeu),
        .jalr_i                        (jalr),
        .pc_i                          (pc),
        .imme_i                        (imme),
        .rs1_data_i                    (rs1_data),
        .rs2_data_i                    (rs2_data),
        .prediction_ex_i               (prediction_ex),
        .jalr_pc_predicted_ex_i        (jalr_pc_predicted_ex),
        .corrected_result_o            (corrected_result),
        .pl_flush_o                    (pl_flush),
        .redirect_pc_o                 (redirect_pc),
        .b_type_branch_failed_o        (b_type_branch_failed),
        .beq_branch_failed_o           (beq_f),
        .bne_branch_failed_o           (bne_f),
        .blt_branch_failed_o           (blt_f),
        .bge_branch_failed_o           (bge_f),
        .bltu_branch_failed_o          (bltu_f),
        .bgeu_branch_failed_o          (bgeu_f),
        .pc_branch_filled_o            (pc_branch_filled),
        .b_type_result_branch_failed_o (b_type_result_branch_failed),
        .mispredict_cnt_o              (mispredict_cnt),
        .resolved_cnt_o                (resolved_cnt)
    );

    always #5 clk = ~clk;

    // kind bit order: {beq, bne, blt, bge, bltu, bgeu}
    typedef struct {
        string       name;
        logic        b_type;
        logic [5:0]  kind;
        logic        jalr;
        logic [31:0] pc;
        logic [31:0] imme;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        pred;
        logic [31:0] jpred;
        logic        exp_corr;
        logic        exp_flush;
        logic [31:0] exp_redir;
    } vec_t;

    function automatic vec_t mk(string n, logic bt, logic [5:0] k, logic j, logic [31:0] p,
                                logic [31:0] im, logic [31:0] a, logic [31:0] b, logic pr,
                                logic [31:0] jp, logic ec, logic ef, logic [31:0] er);
        vec_t v;
        v.name = n; v.b_type = bt; v.kind = k; v.jalr = j; v.pc = p; v.imme = im;
        v.rs1 = a; v.rs2 = b; v.pred = pr; v.jpred = jp;
        v.exp_corr = ec; v.exp_flush = ef; v.exp_redir = er;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        b_type = v.b_type;
        {beq, bne, blt, bge, bltu, bgeu} = v.kind;
        jalr = v.jalr; pc = v.pc; imme = v.imme;
        rs1_data = v.rs1; rs2_data = v.rs2;
        prediction_ex = v.pred; jalr_pc_predicted_ex = v.jpred;
    endtask

    task automatic idle();
        b_type = 1'b0; jalr = 1'b0;
        {beq, bne, blt, bge, bltu, bgeu} = 6'b0;
    endtask

    task automatic run_vec(vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk({v.name, ":corr"}, 32'(corrected_result), 32'(v.exp_corr));
        @(posedge clk);
        #1;
        chk({v.name, ":flush"}, 32'(pl_flush), 32'(v.exp_flush));
        if (v.exp_flush) begin
            chk({v.name, ":redirect"}, redirect_pc, v.exp_redir);
            chk({v.name, ":bfail"}, 32'(b_type_branch_failed), 32'(v.b_type));
            chk({v.name, ":kind"}, 32'({beq_f, bne_f, blt_f, bge_f, bltu_f, bgeu_f}),
                32'(v.b_type ? v.kind : 6'b0));
            chk({v.name, ":pcfill"}, pc_branch_filled, v.pc);
            chk({v.name, ":resfail"}, 32'(b_type_result_branch_failed), 32'(v.pred));
        end else begin
            chk({v.name, ":pcfill0"}, pc_branch_filled, 32'h0);
        end
        idle();
        if (v.exp_flush) begin
            @(posedge clk);
            #1;
            chk({v.name, ":flush_end"}, 32'(pl_flush), 32'h0);
            chk({v.name, ":bundle_clr"}, pc_branch_filled, 32'h0);
        end
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = mk("beq_mis",   1, 6'b100000, 0, 32'h100, 32'h20, 5, 5, 0, 0, 1, 1, 32'h120);
        vecs[1]  = mk("beq_ok",    1, 6'b100000, 0, 32'h100, 32'h20, 5, 5, 1, 0, 1, 0, 0);
        vecs[2]  = mk("bne_ok",    1, 6'b010000, 0, 32'h200, 32'h8,  5, 6, 1, 0, 1, 0, 0);
        vecs[3]  = mk("bne_nt",    1, 6'b010000, 0, 32'h200, 32'h8,  5, 5, 1, 0, 0, 1, 32'h204);
        vecs[4]  = mk("bltu_nt",   1, 6'b000010, 0, 32'h300, 32'h40, 32'hFFFFFFFF, 1, 0, 0,
                      0, 0, 0);
        vecs[5]  = mk("blt_tk",    1, 6'b001000, 0, 32'h300, 32'h40, 32'hFFFFFFFF, 1, 0, 0,
                      1, 1, 32'h340);
        vecs[6]  = mk("bge_tk",    1, 6'b000100, 0, 32'h400, 32'hFFFFFFF0, 1, 32'hFFFFFFFF, 0,
                      0, 1, 1, 32'h3F0);
        vecs[7]  = mk("bgeu_nt",   1, 6'b000001, 0, 32'h400, 32'h10, 1, 32'hFFFFFFFF, 1, 0,
                      0, 1, 32'h404);
        vecs[8]  = mk("jalr_ok",   0, 6'b0, 1, 32'h500, 32'h0, 32'h2003, 0, 0, 32'h2002,
                      0, 0, 0);
        vecs[9]  = mk("jalr_mis",  0, 6'b0, 1, 32'h500, 32'h0, 32'h2003, 0, 0, 32'h3000,
                      0, 1, 32'h2002);
        vecs[10] = mk("tk_wrap",   1, 6'b100000, 0, 32'hFFFFFFF0, 32'h20, 0, 0, 0, 0,
                      1, 1, 32'h10);
        vecs[11] = mk("nt_wrap",   1, 6'b010000, 0, 32'hFFFFFFFC, 32'h20, 7, 7, 1, 0,
                      0, 1, 32'h0);
        vecs[12] = mk("jalr_wrap", 0, 6'b0, 1, 32'h600, 32'h2, 32'hFFFFFFFF, 0, 1, 32'h4,
                      0, 1, 32'h0);

        rst = 1'b1; pl_stall = 1'b0; pl_stall_inner = 1'b0;
        pc = '0; imme = '0; rs1_data = '0; rs2_data = '0;
        prediction_ex = 1'b0; jalr_pc_predicted_ex = '0;
        idle();
        #12;
        chk("rst:flush", 32'(pl_flush), 0);
        chk("rst:redirect", redirect_pc, 0);
        chk("rst:bundle", 32'({b_type_branch_failed, beq_f, bne_f, blt_f, bge_f, bltu_f, bgeu_f,
                               b_type_result_branch_failed}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Reset asserted in the middle of a flush.
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk);
        #1;
        chk("rstmid:flush_on", 32'(pl_flush), 1);
        idle();
        #2 rst = 1'b1;
        #1;
        chk("rstmid:flush", 32'(pl_flush), 0);
        chk("rstmid:pcfill", pc_branch_filled, 0);
        chk("rstmid:bfail", 32'({b_type_branch_failed, beq_f}), 0);
        chk("rstmid:redirect", redirect_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid:after", 32'(pl_flush), 0);
        run_vec(vecs[3]);

        // Mispredicting bne held by PL_stall for three cycles.
        @(negedge clk);
        drive(mk("stall", 1, 6'b010000, 0, 32'h700, 32'h40, 5, 5, 1, 0, 0, 1, 32'h704));
        pl_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall:noflush", 32'(pl_flush), 0);
        end
        @(negedge clk);
        pl_stall = 1'b0;
        @(posedge clk);
        #1;
        chk("stall:flush", 32'(pl_flush), 1);
        chk("stall:redirect", redirect_pc, 32'h704);
        chk("stall:pcfill", pc_branch_filled, 32'h700);
        // Wrong-path branch in EX during FLUSH, with a stall that must not extend the flush.
        drive(vecs[0]);
        pl_stall = 1'b1;
        #1;
        chk("stall:wp_corr", 32'(corrected_result), 0);
        @(posedge clk);
        #1;
        chk("stall:flush_end", 32'(pl_flush), 0);
        idle();
        pl_stall = 1'b0;
        @(posedge clk);
        #1;
        chk("stall:wp_ignored", 32'(pl_flush), 0);

        // One-cycle EX-internal stall.
        @(negedge clk);
        drive(vecs[5]);
        pl_stall_inner = 1'b1;
        @(posedge clk);
        #1;
        chk("inner:noflush", 32'(pl_flush), 0);
        @(negedge clk);
        pl_stall_inner = 1'b0;
        @(posedge clk);
        #1;
        chk("inner:flush", 32'(pl_flush), 1);
        chk("inner:redirect", redirect_pc, 32'h340);
        idle();
        @(posedge clk);
        #1;
        chk("inner:flush_end", 32'(pl_flush), 0);

`ifdef BRU_PERF_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++)
            run_vec(mk("perf", 1, 6'b100000, 0, 32'h100, 32'h20, 5, 5, (i < 3) ? 1'b0 : 1'b1, 0,
                       1, (i < 3) ? 1'b1 : 1'b0, 32'h120));
        chk("perf:resolved", 32'(resolved_cnt), 10);
        chk("perf:mispred", 32'(mispredict_cnt), 3);
        for (int i = 0; i < 8; i++) run_vec(vecs[0]);
        chk("perf:resolved_sat", 32'(resolved_cnt), 15);
        chk("perf:mispred_11", 32'(mispredict_cnt), 11);
`else
        chk("perf:resolved_tied", 32'(resolved_cnt), 0);
        chk("perf:mispred_tied", 32'(mispredict_cnt), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
